// File: rtl/corner_turn_128.sv
`default_nettype none
// ============================================================================
// Module   : corner_turn_128
// Purpose  : Ping/pong corner-turn (matrix transpose) buffer placed between
//            the row FFT and the column FFT of a 2D FFT. Words arrive in
//            row-major order and leave in column-major order, bit-exact.
//
// Ports    : clk            - sole clock, rising edge
//            rst            - asynchronous active-high reset
//            s_axis_tdata   - input complex word {imag[63:32], real[31:0]}
//            s_axis_tvalid  - input word valid
//            s_axis_tready  - block can accept an input word
//            s_axis_tlast   - upstream end-of-row marker (checked only)
//            m_axis_tdata   - output word, column-major order
//            m_axis_tvalid  - output word valid
//            m_axis_tready  - downstream accepts the output word
//            m_axis_tlast   - last word of each column
//            frame_done     - one-cycle pulse after a frame's final output
//            err_tlast      - sticky tlast / row-position mismatch flag
//
// Revision : 1.0 - initial release
// ============================================================================
module corner_turn_128 #(
    parameter int DIM = 128,
    parameter int DW  = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
    output logic          frame_done,
    output logic          err_tlast
);

    localparam int c_LW = $clog2(DIM);
    // One bank-select bit above the row/column bits.
    localparam int c_AW = 2 * c_LW + 1;
    localparam int c_DEPTH = 2 * DIM * DIM;
    localparam logic [c_LW-1:0] c_MAX = {c_LW{1'b1}};

    // Bank states. Bit 1 set means the bank holds a complete frame, so the
    // write side may use a bank only while bit 1 is clear.
    localparam logic [1:0] c_EMPTY    = 2'd0;
    localparam logic [1:0] c_FILLING  = 2'd1;
    localparam logic [1:0] c_FULL     = 2'd2;
    localparam logic [1:0] c_DRAINING = 2'd3;

    // ------------------------------------------------------------------
    // Storage: both banks share one array, addressed {bank, row, col}.
    // ------------------------------------------------------------------
    logic [DW-1:0]   r_mem [c_DEPTH];
    logic [DW-1:0]   r_mem_q;

    logic [1:0]      w_bank_state [2];

    // Write side
    logic            r_in_en;
    logic            r_wr_bank;
    logic [c_LW-1:0] r_wr_row;
    logic [c_LW-1:0] r_wr_col;
    logic            r_err_tlast;
    logic            w_wr_fire;
    logic            w_wr_row_end;
    logic            w_wr_last;
    logic [c_AW-1:0] w_wr_addr;

    // Read address generator. r_rd_row is the fast index (k mod DIM),
    // r_rd_col the slow one (k div DIM).
    logic            r_rd_bank;
    logic [c_LW-1:0] r_rd_row;
    logic [c_LW-1:0] r_rd_col;
    logic            r_rd_busy;
    logic            w_rd_avail;
    logic            w_rd_en;
    logic            w_rd_start;
    logic            w_rd_last;
    logic [c_AW-1:0] w_rd_addr;

    // Stage 1: memory read register plus its sideband flags.
    logic            r_s1_valid;
    logic            r_s1_last;
    logic            r_s1_flast;
    logic            r_s1_bank;
    logic            w_s1_take;

    // Skid slot: catches the word already in flight when the output stalls.
    logic            r_sk_valid;
    logic [DW-1:0]   r_sk_data;
    logic            r_sk_last;
    logic            r_sk_flast;
    logic            r_sk_bank;

    // Output register.
    logic            r_out_valid;
    logic [DW-1:0]   r_out_data;
    logic            r_out_last;
    logic            r_out_flast;
    logic            r_out_bank;
    logic            w_out_load;
    logic            w_out_done;
    logic            r_frame_done;

    // ------------------------------------------------------------------
    // Per-bank state machines
    // ------------------------------------------------------------------
    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            logic [1:0] r_state;
            logic [1:0] w_state_nxt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= c_EMPTY;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                case (r_state)
                    c_EMPTY: begin
                        if (w_wr_fire && (r_wr_bank == 1'(b))) begin
                            w_state_nxt = c_FILLING;
                        end
                    end
                    c_FILLING: begin
                        if (w_wr_last && (r_wr_bank == 1'(b))) begin
                            w_state_nxt = c_FULL;
                        end
                    end
                    c_FULL: begin
                        if (w_rd_start && (r_rd_bank == 1'(b))) begin
                            w_state_nxt = c_DRAINING;
                        end
                    end
                    c_DRAINING: begin
                        // Released only once the frame's final word has been
                        // accepted downstream, not when its last read issues.
                        if (w_out_done && (r_out_bank == 1'(b))) begin
                            w_state_nxt = c_EMPTY;
                        end
                    end
                    default: begin
                        w_state_nxt = c_EMPTY;
                    end
                endcase
            end

            assign w_bank_state[b] = r_state;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    // r_in_en holds tready low through reset and releases it on the first
    // edge afterwards.
    assign s_axis_tready = r_in_en & ~w_bank_state[r_wr_bank][1];
    assign w_wr_fire     = s_axis_tvalid & s_axis_tready;
    assign w_wr_row_end  = (r_wr_col == c_MAX);
    assign w_wr_last     = w_wr_fire & w_wr_row_end & (r_wr_row == c_MAX);
    assign w_wr_addr     = {r_wr_bank, r_wr_row, r_wr_col};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_en     <= 1'b0;
            r_wr_bank   <= 1'b0;
            r_wr_row    <= '0;
            r_wr_col    <= '0;
            r_err_tlast <= 1'b0;
        end else begin
            r_in_en <= 1'b1;
            if (w_wr_fire) begin
                // tlast is only checked; the counters are the sole authority
                // on word position.
                if (s_axis_tlast != w_wr_row_end) begin
                    r_err_tlast <= 1'b1;
                end
                if (w_wr_row_end) begin
                    r_wr_col <= '0;
                    if (r_wr_row == c_MAX) begin
                        r_wr_row  <= '0;
                        r_wr_bank <= ~r_wr_bank;
                    end else begin
                        r_wr_row <= r_wr_row + 1'b1;
                    end
                end else begin
                    r_wr_col <= r_wr_col + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read address generator
    // ------------------------------------------------------------------
    // Reads continue while a bank is in progress, or start on a FULL bank.
    // Issue is throttled only by the skid slot, which keeps m_axis_tready
    // out of the address path.
    assign w_rd_avail = r_rd_busy | (w_bank_state[r_rd_bank] == c_FULL);
    assign w_rd_en    = w_rd_avail & ~r_sk_valid;
    assign w_rd_start = w_rd_en & ~r_rd_busy;
    assign w_rd_last  = w_rd_en & (r_rd_row == c_MAX) & (r_rd_col == c_MAX);
    assign w_rd_addr  = {r_rd_bank, r_rd_row, r_rd_col};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_bank <= 1'b0;
            r_rd_row  <= '0;
            r_rd_col  <= '0;
            r_rd_busy <= 1'b0;
        end else if (w_rd_en) begin
            // DIM is a power of two, so the row index wraps on its own.
            r_rd_row <= r_rd_row + 1'b1;
            if (r_rd_row == c_MAX) begin
                r_rd_col <= r_rd_col + 1'b1;
            end
            if (w_rd_last) begin
                // Hand over to the other bank immediately so a FULL bank
                // behind this one follows without a gap.
                r_rd_bank <= ~r_rd_bank;
                r_rd_busy <= 1'b0;
            end else begin
                r_rd_busy <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory array. The read register only updates on a read, so it holds
    // its word while the downstream stages are blocked.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_wr_addr] <= s_axis_tdata;
        end
        if (w_rd_en) begin
            r_mem_q <= r_mem[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline: stage 1 -> (skid) -> output register
    // ------------------------------------------------------------------
    assign w_out_load = ~r_out_valid | m_axis_tready;
    assign w_out_done = r_out_valid & m_axis_tready & r_out_flast;
    // Stage 1 empties when its word moves to the output or to the skid slot.
    assign w_s1_take  = r_s1_valid & (w_out_load | ~r_sk_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_flast   <= 1'b0;
            r_s1_bank    <= 1'b0;
            r_sk_valid   <= 1'b0;
            r_sk_data    <= '0;
            r_sk_last    <= 1'b0;
            r_sk_flast   <= 1'b0;
            r_sk_bank    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_flast  <= 1'b0;
            r_out_bank   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_out_done;

            if (w_out_load) begin
                if (r_sk_valid) begin
                    // Skid is older than stage 1, so it goes out first.
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_sk_data;
                    r_out_last  <= r_sk_last;
                    r_out_flast <= r_sk_flast;
                    r_out_bank  <= r_sk_bank;
                    r_sk_valid  <= r_s1_valid;
                    r_sk_data   <= r_mem_q;
                    r_sk_last   <= r_s1_last;
                    r_sk_flast  <= r_s1_flast;
                    r_sk_bank   <= r_s1_bank;
                end else if (r_s1_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_mem_q;
                    r_out_last  <= r_s1_last;
                    r_out_flast <= r_s1_flast;
                    r_out_bank  <= r_s1_bank;
                end else begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_out_flast <= 1'b0;
                end
            end else if (!r_sk_valid && r_s1_valid) begin
                // Output stalled: park the in-flight word.
                r_sk_valid <= 1'b1;
                r_sk_data  <= r_mem_q;
                r_sk_last  <= r_s1_last;
                r_sk_flast <= r_s1_flast;
                r_sk_bank  <= r_s1_bank;
            end

            if (w_rd_en) begin
                r_s1_valid <= 1'b1;
                r_s1_last  <= (r_rd_row == c_MAX);
                r_s1_flast <= w_rd_last;
                r_s1_bank  <= r_rd_bank;
            end else if (w_s1_take) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_out_data;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tlast  = r_out_last;
    assign frame_done    = r_frame_done;
    assign err_tlast     = r_err_tlast;

endmodule
`default_nettype wire

// File: tb/tb_corner_turn_128.sv
`default_nettype none
// ============================================================================
// Module   : tb_corner_turn_128
// Purpose  : Self-checking bench for corner_turn_128 at DIM=4. Input word
//            (r,c) of frame t is {t, 8'hRC}; output word k must be
//            {t, (k mod 4, k div 4)} from a hand-written table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_corner_turn_128;

    localparam int DIM = 4;
    localparam int DW  = 64;
    localparam int c_NW = DIM * DIM;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          frame_done;
    logic          err_tlast;

    corner_turn_128 #(
        .DIM (DIM),
        .DW  (DW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_done    (frame_done),
        .err_tlast     (err_tlast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          k;
        logic [31:0] exp_re;
        bit          exp_last;
    } vec_t;
    vec_t tbl [c_NW];

    int checks   = 0;
    int failures = 0;

    logic [63:0] got_q [$];
    bit          got_last_q [$];
    int          got_cyc_q [$];
    int          frame_done_cnt = 0;
    bit          ready_rand  = 1'b0;
    bit          ready_fixed = 1'b1;
    bit          saw_stall   = 1'b0;
    bit          prev_stall  = 1'b0;
    logic [63:0] prev_data   = '0;
    logic        prev_last   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Consumer: drives m_axis_tready at each negedge, logs accepted words
    // and checks the output holds steady across stalls.
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_valid_hold", 64'(m_axis_tvalid), 64'd1);
                chk("stall_data_hold", m_axis_tdata, prev_data);
                chk("stall_last_hold", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (frame_done) frame_done_cnt++;
            m_axis_tready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back(m_axis_tdata);
                got_last_q.push_back(m_axis_tlast);
                got_cyc_q.push_back(cyc);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic put_word(input logic [63:0] d, input logic l);
        int t = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t > 0) saw_stall = 1'b1;
        if (!s_axis_tready) begin
            checks++;
            failures++;
            $display("FAIL write_timeout actual=tready_low required=accept");
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int tag);
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                put_word({32'(tag), 32'(r * 16 + c)}, (c == DIM - 1));
            end
        end
    endtask

    task automatic wait_outputs(input int n);
        int t = 0;
        while (got_q.size() < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("output_count", 64'(got_q.size()), 64'(n));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input int tag, input int base);
        for (int k = 0; k < c_NW; k++) begin
            chk($sformatf("t%0d_k%0d_data", tag, tbl[k].k), got_q[base + k],
                {32'(tag), tbl[k].exp_re});
            chk($sformatf("t%0d_k%0d_last", tag, tbl[k].k), 64'(got_last_q[base + k]),
                64'(tbl[k].exp_last));
        end
    endtask

    task automatic clear_q();
        got_q.delete();
        got_last_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
        chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, "_m_tlast"},  64'(m_axis_tlast),  64'd0);
        chk({tag, "_m_tdata"},  m_axis_tdata,       64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done),  64'd0);
        chk({tag, "_err_tlast"},  64'(err_tlast),   64'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fd0;

        // Column-major readout of a 4x4 frame whose word (r,c) is 0xRC.
        tbl[0]  = '{0,  32'h00, 1'b0};
        tbl[1]  = '{1,  32'h10, 1'b0};
        tbl[2]  = '{2,  32'h20, 1'b0};
        tbl[3]  = '{3,  32'h30, 1'b1};
        tbl[4]  = '{4,  32'h01, 1'b0};
        tbl[5]  = '{5,  32'h11, 1'b0};
        tbl[6]  = '{6,  32'h21, 1'b0};
        tbl[7]  = '{7,  32'h31, 1'b1};
        tbl[8]  = '{8,  32'h02, 1'b0};
        tbl[9]  = '{9,  32'h12, 1'b0};
        tbl[10] = '{10, 32'h22, 1'b0};
        tbl[11] = '{11, 32'h32, 1'b1};
        tbl[12] = '{12, 32'h03, 1'b0};
        tbl[13] = '{13, 32'h13, 1'b0};
        tbl[14] = '{14, 32'h23, 1'b0};
        tbl[15] = '{15, 32'h33, 1'b1};

        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        // ---- Reset state and tready release ----
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        chk("tready_before_first_edge", 64'(s_axis_tready), 64'd0);
        @(negedge clk);
        chk("tready_after_first_edge", 64'(s_axis_tready), 64'd1);

        // ---- Single frame, latency, contiguity ----
        fd0 = frame_done_cnt;
        send_frame(1);
        chk("lat_edge0_tvalid", 64'(m_axis_tvalid), 64'd0);
        @(negedge clk);
        chk("lat_edge1_tvalid", 64'(m_axis_tvalid), 64'd0);
        @(negedge clk);
        chk("lat_edge2_tvalid", 64'(m_axis_tvalid), 64'd1);
        wait_outputs(c_NW);
        check_frame(1, 0);
        chk("t1_contiguous", 64'(got_cyc_q[c_NW - 1] - got_cyc_q[0]), 64'(c_NW - 1));
        chk("t1_frame_done_cnt", 64'(frame_done_cnt - fd0), 64'd1);
        chk("t1_err_tlast", 64'(err_tlast), 64'd0);
        clear_q();

        // ---- Three frames back to back: only the third must stall ----
        fd0 = frame_done_cnt;
        saw_stall = 1'b0;
        send_frame(2);
        chk("b2b_f1_stall", 64'(saw_stall), 64'd0);
        saw_stall = 1'b0;
        send_frame(3);
        chk("b2b_f2_stall", 64'(saw_stall), 64'd0);
        saw_stall = 1'b0;
        send_frame(4);
        chk("b2b_f3_stall", 64'(saw_stall), 64'd1);
        wait_outputs(3 * c_NW);
        check_frame(2, 0);
        check_frame(3, c_NW);
        check_frame(4, 2 * c_NW);
        chk("b2b_frame_done_cnt", 64'(frame_done_cnt - fd0), 64'd3);
        clear_q();

        // ---- Random downstream backpressure ----
        fd0 = frame_done_cnt;
        ready_rand = 1'b1;
        send_frame(5);
        wait_outputs(c_NW);
        ready_rand = 1'b0;
        @(negedge clk);
        check_frame(5, 0);
        chk("rand_frame_done_cnt", 64'(frame_done_cnt - fd0), 64'd1);
        clear_q();

        // ---- Early tlast on row 0: sticky error, data still transposed ----
        put_word({32'd6, 32'h00}, 1'b0);
        chk("err_before_bad", 64'(err_tlast), 64'd0);
        put_word({32'd6, 32'h01}, 1'b1);
        chk("err_after_bad", 64'(err_tlast), 64'd1);
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                if (r == 0 && c < 2) continue;
                put_word({32'd6, 32'(r * 16 + c)}, (r != 0) && (c == DIM - 1));
            end
        end
        wait_outputs(c_NW);
        check_frame(6, 0);
        chk("err_still_set", 64'(err_tlast), 64'd1);
        clear_q();

        // ---- Reset mid-frame discards it; a fresh frame follows ----
        for (int i = 0; i < 9; i++) begin
            put_word({32'd7, 32'((i / DIM) * 16 + (i % DIM))}, ((i % DIM) == DIM - 1));
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midreset_no_output", 64'(got_q.size()), 64'd0);
        fd0 = frame_done_cnt;
        send_frame(8);
        wait_outputs(c_NW);
        check_frame(8, 0);
        chk("fresh_frame_done_cnt", 64'(frame_done_cnt - fd0), 64'd1);
        chk("fresh_err_tlast", 64'(err_tlast), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/corner_turn_128.md
CORNER_TURN_128 -- requirements
Module: corner_turn_128

Interface
REQ-001 SHALL have parameter DIM, default 128, giving the matrix side length; legal values are powers of two from 4 to 128.
REQ-002 SHALL have parameter DW, default 64, giving the complex word width: [63:32] is the imaginary part and [31:0] the real part, both float32.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 s_axis_tdata  in  DW  row-major 1D-FFT output word.
REQ-006 s_axis_tvalid  in  1  input word valid.
REQ-007 s_axis_tready  out  1  block can accept a word.
REQ-008 s_axis_tlast  in  1  upstream end-of-row marker.
REQ-009 m_axis_tdata  out  DW  column-major word sent to the second FFT.
REQ-010 m_axis_tvalid  out  1  output word valid.
REQ-011 m_axis_tready  in  1  downstream accepts the word.
REQ-012 m_axis_tlast  out  1  high on the last word of each column.
REQ-013 frame_done  out  1  one-cycle pulse after the final word of a transposed frame is accepted.
REQ-014 err_tlast  out  1  sticky flag for a tlast/row-position mismatch.

Function
REQ-015 SHALL hold two banks (ping/pong), each DIM*DIM words of DW bits, with independent write and read pointers.
REQ-016 Each bank SHALL have a state EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY; no other transitions are allowed.
REQ-017 s_axis_tready SHALL be 1 only when the current write bank is EMPTY or FILLING.
REQ-018 A write handshake (tvalid & tready) SHALL store the word at address wr_row*DIM + wr_col; wr_col increments, wraps at DIM-1 and then increments wr_row.
REQ-019 On the handshake with wr_row=wr_col=DIM-1, the bank SHALL become FULL, the write pointer SHALL toggle to the other bank, and the counters SHALL clear.
REQ-020 err_tlast SHALL set when s_axis_tlast differs from (wr_col==DIM-1) on a handshake; data SHALL still be written at the counter position, with no resynchronisation.
REQ-021 Reads SHALL start only from a FULL bank, which becomes DRAINING; the k-th output (k=0..DIM*DIM-1) SHALL be the word at address (k mod DIM)*DIM + (k div DIM).
REQ-022 The read path SHALL have a 1-cycle memory read plus an output register with a skid slot, so m_axis_tdata/tvalid stay stable while tvalid=1 and tready=0.
REQ-023 With m_axis_tready held at 1, the output SHALL sustain one word per cycle with no bubbles inside a frame or between back-to-back FULL banks.
REQ-024 m_axis_tvalid SHALL first rise exactly 2 cycles after the edge that accepts a frame's final write, provided the read side is idle.
REQ-025 m_axis_tlast SHALL be 1 when (k mod DIM)==DIM-1.
REQ-026 On acceptance of k=DIM*DIM-1, the bank SHALL return to EMPTY and frame_done SHALL pulse on the next cycle.
REQ-027 A write handshake and a final read of the same bank on the same edge SHALL NOT conflict: the bank becomes EMPTY, and write acceptance for it starts the following cycle.
REQ-028 When both banks are FULL or DRAINING, s_axis_tready SHALL be 0 and no input SHALL be lost or overwritten.
REQ-029 Bank contents SHALL be preserved exactly; the block SHALL perform no arithmetic on the data.

Reset
REQ-030 While rst=1: both banks EMPTY, all pointers 0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, frame_done=0, err_tlast=0, m_axis_tdata=0.
REQ-031 s_axis_tready SHALL rise on the first clk edge after rst deasserts.
REQ-032 Reset mid-frame SHALL discard all partial and full frames; memory contents need not be cleared.

Verification
REQ-033 Load a 128x128 frame with word = {row, col} at constant tvalid, tready=1 -> output word k equals {k mod 128, k div 128}, tlast every 128th word, frame_done once, err_tlast=0.
REQ-034 Send three frames back to back with tready=1 -> frame 3 stalls (s_axis_tready=0) until frame 1 finishes draining, and all 3*16384 words come out in order.
REQ-035 Toggle m_axis_tready randomly at 50% -> no duplicated or dropped word, and tdata is stable across every stall.
REQ-036 Assert tlast at col=5 on row 0 -> err_tlast=1 from the next cycle until rst; the output frame is still correctly transposed.
REQ-037 Assert rst after 9000 input words -> all outputs take their reset values; a fresh frame then transposes correctly.
REQ-038 Measure cycles from the final write to the first m_axis_tvalid -> exactly 2.
